// File: rtl/image_sort_engine_pkg.sv
// image_sort_engine_pkg: shared constants, record layout, FSM states and pixel classifier
// for the image sorting engine.
package image_sort_engine_pkg;
    localparam int IMAGE_NUM   = 32;
    localparam int IMAGE_SIZE  = 128;
    localparam int PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE;
    localparam int DIV_LAT     = 24;
    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;
    // Field order makes the packed value itself the sort key.
    typedef struct packed {
        logic [1:0] color;
        logic [7:0] intensity;
        logic [4:0] index;
    } record_t;
    typedef enum logic [1:0] {S_ACCUM, S_DIVIDE, S_INSERT, S_OUTPUT} state_t;
    function automatic logic [1:0] classify(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return (r >= g && r >= b) ? COL_R : (g >= b) ? COL_G : COL_B;
    endfunction
endpackage

// File: rtl/image_sort_engine_divider.sv
// seq_divider: restoring divider developing an 8-bit quotient, one bit per cycle after start.
// The caller guarantees dividend < divisor * 256, so only the low 8 quotient bits exist.
module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [21:0] i_dividend,
    input  logic [14:0] i_divisor,
    output logic [7:0]  o_quotient,
    output logic        o_done
);
    logic [21:0] r_rem;
    logic [14:0] r_dvs;
    logic [2:0]  r_bit;
    logic        r_run;
    logic [21:0] w_shift;
    logic        w_ge;
    assign w_shift = {7'd0, r_dvs} << r_bit;
    assign w_ge    = r_rem >= w_shift;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_dvs      <= '0;
            r_bit      <= '0;
            r_run      <= 1'b0;
            o_quotient <= '0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_rem      <= i_dividend;
                r_dvs      <= i_divisor;
                r_bit      <= 3'd7;
                r_run      <= 1'b1;
                o_quotient <= '0;
            end else if (r_run) begin
                r_rem             <= w_ge ? r_rem - w_shift : r_rem;
                o_quotient[r_bit] <= w_ge;
                r_bit             <= r_bit - 3'd1;
                r_run             <= r_bit != 3'd0;
                o_done            <= r_bit == 3'd0;
            end
        end
    end
endmodule

// File: rtl/image_sort_engine.sv
// image_sort_engine: classifies streamed RGB images by dominant colour and average intensity,
// then emits the batch's image indices sorted by {colour, intensity, index}.
module image_sort_engine #(
    parameter int IMAGE_NUM  = image_sort_engine_pkg::IMAGE_NUM,
    parameter int IMAGE_SIZE = image_sort_engine_pkg::IMAGE_SIZE,
    parameter int DIV_LAT    = image_sort_engine_pkg::DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  image_in_index,
    input  logic [23:0] pixel_in,
    output logic        busy,
    output logic        out_valid,
    output logic [1:0]  color_index,
    output logic [4:0]  image_out_index
);
    import image_sort_engine_pkg::*;
    localparam int PIX = IMAGE_SIZE * IMAGE_SIZE;
    state_t      r_state;
    logic [14:0] r_pix;
    logic [14:0] r_cnt [3];
    logic [21:0] r_sum [3];
    logic [7:0]  r_lat;
    logic [5:0]  r_img;
    logic [5:0]  r_ocnt;
    logic [4:0]  r_idx;
    logic [7:0]  r_int;
    logic        r_busy;
    logic        r_valid;
    logic [1:0]  r_col_out;
    logic [4:0]  r_idx_out;
    record_t     r_list [IMAGE_NUM];
    logic [1:0]  w_pcol;
    logic [7:0]  w_pval;
    logic [1:0]  w_dcol;
    logic [14:0] w_dcnt;
    logic [21:0] w_dsum;
    logic        w_div_start;
    logic        w_div_done;
    logic [7:0]  w_quot;
    record_t     w_rec;
    logic [IMAGE_NUM-1:0] w_le;
    record_t     w_ins [IMAGE_NUM];
    assign w_pcol = classify(pixel_in[23:16], pixel_in[15:8], pixel_in[7:0]);
    assign w_pval = w_pcol == COL_R ? pixel_in[23:16] : w_pcol == COL_G ? pixel_in[15:8] : pixel_in[7:0];
    assign w_dcol = (r_cnt[0] >= r_cnt[1] && r_cnt[0] >= r_cnt[2]) ? COL_R : (r_cnt[1] >= r_cnt[2]) ? COL_G : COL_B;
    assign w_dcnt = w_dcol == COL_R ? r_cnt[0] : w_dcol == COL_G ? r_cnt[1] : r_cnt[2];
    assign w_dsum = w_dcol == COL_R ? r_sum[0] : w_dcol == COL_G ? r_sum[1] : r_sum[2];
    assign w_div_start = r_state == S_DIVIDE && r_lat == 8'd0;
    assign w_rec = {w_dcol, r_int, r_idx};
    assign busy            = r_busy;
    assign out_valid       = r_valid;
    assign color_index     = r_col_out;
    assign image_out_index = r_idx_out;
    seq_divider u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_dsum),
        .i_divisor  (w_dcnt),
        .o_quotient (w_quot),
        .o_done     (w_div_done)
    );
    // Entries not greater than the new record stay; the first greater slot takes it, the rest shift up.
    for (genvar j = 0; j < IMAGE_NUM; j++) begin : g_ins
        assign w_le[j] = 6'(j) < r_img && r_list[j] <= w_rec;
        if (j == 0) begin : g_head
            assign w_ins[j] = w_le[j] ? r_list[j] : w_rec;
        end else begin : g_tail
            assign w_ins[j] = w_le[j] ? r_list[j] : w_le[j-1] ? w_rec : r_list[j-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_ACCUM;
            r_pix     <= '0;
            r_lat     <= '0;
            r_img     <= '0;
            r_ocnt    <= '0;
            r_idx     <= '0;
            r_int     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_col_out <= '0;
            r_idx_out <= '0;
            for (int c = 0; c < 3; c++) begin
                r_cnt[c] <= '0;
                r_sum[c] <= '0;
            end
            for (int k = 0; k < IMAGE_NUM; k++) r_list[k] <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_div_done) r_int <= w_quot;
            case (r_state)
                S_ACCUM: begin
                    for (int c = 0; c < 3; c++) begin
                        if (w_pcol == 2'(c)) begin
                            r_cnt[c] <= r_cnt[c] + 15'd1;
                            r_sum[c] <= r_sum[c] + 22'(w_pval);
                        end
                    end
                    r_pix <= r_pix == 15'(PIX - 1) ? '0 : r_pix + 15'd1;
                    if (r_pix == 15'(PIX - 1)) begin
                        r_busy  <= 1'b1;
                        r_state <= S_DIVIDE;
                        r_lat   <= '0;
                        r_idx   <= image_in_index;
                    end
                end
                S_DIVIDE: begin
                    r_lat <= r_lat + 8'd1;
                    if (r_lat == 8'(DIV_LAT - 2)) r_state <= S_INSERT;
                end
                S_INSERT: begin
                    r_list <= w_ins;
                    for (int c = 0; c < 3; c++) begin
                        r_cnt[c] <= '0;
                        r_sum[c] <= '0;
                    end
                    r_img   <= r_img + 6'd1;
                    r_ocnt  <= '0;
                    r_busy  <= r_img == 6'(IMAGE_NUM - 1);
                    r_state <= r_img == 6'(IMAGE_NUM - 1) ? S_OUTPUT : S_ACCUM;
                end
                S_OUTPUT: begin
                    if (r_ocnt == 6'(IMAGE_NUM)) begin
                        r_busy  <= 1'b0;
                        r_img   <= '0;
                        r_state <= S_ACCUM;
                        for (int k = 0; k < IMAGE_NUM; k++) r_list[k] <= '0;
                    end else begin
                        r_valid   <= 1'b1;
                        r_col_out <= r_list[r_ocnt[4:0]].color;
                        r_idx_out <= r_list[r_ocnt[4:0]].index;
                        r_ocnt    <= r_ocnt + 6'd1;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_image_sort_engine.sv
// tb_image_sort_engine: directed batches on a reduced image size, outputs checked
// against a scoreboard of bench-computed, bench-sorted records.
module tb_image_sort_engine;
    localparam int N    = 32;
    localparam int SIZE = 8;
    localparam int PIX  = SIZE * SIZE;
    localparam int LAT  = 24;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  image_in_index = '0;
    logic [23:0] pixel_in = '0;
    logic        busy;
    logic        out_valid;
    logic [1:0]  color_index;
    logic [4:0]  image_out_index;
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t_last = 0;
    int t_first = 0;
    int run = 0;
    logic [14:0] exp_q [$];
    logic [14:0] e;
    image_sort_engine #(.IMAGE_NUM(N), .IMAGE_SIZE(SIZE), .DIV_LAT(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .image_in_index  (image_in_index),
        .pixel_in        (pixel_in),
        .busy            (busy),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        assert (got === expv) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask
    function automatic logic [23:0] pix(input int b, input int idx, input int p);
        logic [7:0] r, g, bl;
        r  = 8'(idx * 37 + p * 11 + b * 5);
        g  = 8'(idx * 53 + p * 7 + 91 + b);
        bl = 8'(idx * 19 + p * 29 + 17 + b * 3);
        if (b == 0) return {8'(100 + idx), 8'd10, 8'd10};
        if (b == 1) return idx == 5 ? 24'h0000FF : idx == 3 ? 24'h00FF00 : 24'h640000;
        if (b == 2 && idx == 0) return 24'h323232;
        if (b == 2 && idx == 1) return p < PIX / 2 ? 24'h005A00 : 24'h00005A;
        if (b == 2 && idx == 2) return p < PIX / 2 ? 24'hFF0000 : 24'hFE0000;
        if (b == 2 && idx == 9) return 24'hFE0000;
        return {r, g, bl};
    endfunction
    function automatic logic [14:0] model(input int b, input int idx);
        int cnt [3];
        int sum [3];
        int ch [3];
        int d;
        logic [23:0] px;
        cnt = '{0, 0, 0};
        sum = '{0, 0, 0};
        for (int p = 0; p < PIX; p++) begin
            px = pix(b, idx, p);
            ch[0] = int'(px[23:16]);
            ch[1] = int'(px[15:8]);
            ch[2] = int'(px[7:0]);
            d = (ch[0] >= ch[1] && ch[0] >= ch[2]) ? 0 : (ch[1] >= ch[2]) ? 1 : 2;
            cnt[d]++;
            sum[d] += ch[d];
        end
        d = (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) ? 0 : (cnt[1] >= cnt[2]) ? 1 : 2;
        return {2'(d), 8'(sum[d] / cnt[d]), 5'(idx)};
    endfunction
    task automatic expect_batch(input int b);
        logic [14:0] k [N];
        logic [14:0] t;
        for (int i = 0; i < N; i++) k[i] = model(b, i);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (k[j] > k[j+1]) begin
                    t = k[j];
                    k[j] = k[j+1];
                    k[j+1] = t;
                end
        for (int i = 0; i < N; i++) exp_q.push_back(k[i]);
    endtask
    // Called at a negedge; every non-busy edge consumes a pixel, so the bench never idles mid-batch.
    task automatic send_image(input int b, input int idx, input int n_pix, input bit last);
        int w;
        for (int p = 0; p < n_pix; p++) begin
            w = 0;
            while (busy && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (w >= 500) begin
                $display("FAIL busy_stuck: busy still %0d after %0d cycles", busy, w);
                $fatal(1);
            end
            image_in_index = 5'(idx);
            pixel_in = pix(b, idx, p);
            @(negedge clk);
        end
        if (n_pix < PIX) return;
        t_last = cyc;
        image_in_index = ~5'(idx);
        pixel_in = '1;
        w = 0;
        while (busy && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (last) chk("busy_out_len", 32'(w >= LAT + 32 && w <= LAT + 34), 1);
        else chk("busy_len", w, LAT);
    endtask
    task automatic run_batch(input int b, input int mul, input int add);
        expect_batch(b);
        for (int i = 0; i < N; i++) send_image(b, (i * mul + add) % N, PIX, i == N - 1);
        chk("out_latency", 32'(t_first > t_last && t_first - t_last <= LAT + 2), 1);
        chk("q_drained", exp_q.size(), 0);
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (run == 0) t_first = cyc;
                run++;
                chk("q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_color", color_index, e[14:13]);
                    chk("out_index", image_out_index, e[4:0]);
                end
            end else if (run != 0) begin
                chk("valid_run", run, N);
                run = 0;
            end
        end
    end
    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_color", color_index, 0);
        chk("rst_index", image_out_index, 0);
        reset = 1'b0;
        run_batch(0, 1, 0);
        run_batch(1, 1, 0);
        run_batch(2, 5, 7);
        for (int i = 0; i < 10; i++) send_image(3, i, PIX, 1'b0);
        send_image(3, 10, 20, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_color", color_index, 0);
        chk("mid_rst_index", image_out_index, 0);
        reset = 1'b0;
        chk("post_rst_busy", busy, 0);
        run_batch(4, 7, 3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
